cache_refill_unit: RTL and testbench
====================================

Name: cache_refill_unit

Overview:
Miss-handling stage directly downstream of the 4-way set-associative cache controller. It accepts one read-miss at a time and picks a victim way: the first invalid way, otherwise the per-set tree pseudo-LRU. It fetches the word from main memory over a req/ack handshake, then returns a one-cycle fill command that the controller writes into its data, tag and valid arrays. It also takes hit notifications from the controller to keep the replacement state current.

Parameters:
INDEX_W, 8, set index width (address bits [9:2]); number of sets = 2**INDEX_W
TAG_W, 22, tag width (address bits [31:10])
DATA_W, 32, word width of cache and memory data

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
miss_valid  input  1  controller presents a read miss
miss_ready  output  1  block can accept a miss this cycle
miss_addr  input  32  byte address of the missing word
miss_way_valid  input  4  valid bits of the 4 ways of the addressed set, sampled with the miss
hit_valid  input  1  controller had a hit this cycle
hit_index  input  INDEX_W  set index of the hit
hit_way  input  2  way that hit
mem_req  output  1  memory read request, held until acknowledged
mem_addr  output  32  word-aligned read address
mem_ack  input  1  memory returns data this cycle
mem_rdata  input  DATA_W  read data, valid with mem_ack
fill_valid  output  1  one-cycle fill command to the cache arrays
fill_way  output  2  way to overwrite
fill_index  output  INDEX_W  set to write
fill_tag  output  TAG_W  tag to write; controller sets valid=1
fill_data  output  DATA_W  data to write and to forward as read result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-high. All outputs are registered.
  - State goes to IDLE. mem_req=0, fill_valid=0, busy=0, miss_ready=1.
  - mem_addr, fill_way, fill_index, fill_tag and fill_data go to 0.
  - All PLRU bits of all sets are cleared to 0.
  - Reset overrides any operation in flight. mem_req drops at that edge, and any later mem_ack is ignored.
- FSM states: IDLE -> REQ -> FILL -> IDLE.
  - IDLE: miss_ready=1. When miss_valid=1:
    - latch index = miss_addr[9:2] and tag = miss_addr[31:10];
    - set mem_addr = {miss_addr[31:2],2'b00};
    - select the victim, assert mem_req, go to REQ.
  - REQ: miss_ready=0, mem_req=1. When mem_ack=1: latch mem_rdata, drop mem_req, go to FILL. Memory latency is unbounded; there is no timeout.
  - FILL: fill_valid=1 for exactly this one cycle, with fill_way, fill_index, fill_tag and fill_data stable. The PLRU update for the filled way is applied at this edge. Next state is IDLE.
- Victim selection is decided at acceptance.
  - If any miss_way_valid bit is 0, the victim is the lowest-numbered invalid way.
  - Otherwise the victim comes from the set's PLRU bits {b0,b1,b2}:
    - b0=0 -> b1=0 gives way0, b1=1 gives way1;
    - b0=1 -> b2=0 gives way2, b2=1 gives way3.
- PLRU update on an access to way w sets the bits to point away from w; untouched bits keep their value.
  - way0: b0=1, b1=1
  - way1: b0=1, b1=0
  - way2: b0=0, b2=1
  - way3: b0=0, b2=0
- Hit updates are applied on any cycle with hit_valid=1, in any state.
  - If a hit update and the FILL update target the same set in the same cycle, apply the hit update first, then the fill update. The fill wins on any bit both write.
- Latency (cycle 0 = acceptance edge):
  - mem_req is high from cycle 1.
  - If mem_ack arrives at cycle k (k>=1), fill_valid is high at cycle k+1.
  - Minimum latency, miss to fill, is 2 cycles.
- Boundary conditions:
  - miss_valid while busy is not accepted; the controller must hold its request.
  - A new miss is accepted no earlier than the cycle after FILL, i.e. back-to-back misses have 1 idle cycle between them.
  - mem_ack outside REQ is ignored.
  - miss_addr[1:0] is ignored.

Test Plan:
- Reset, then miss_addr=0x0000_0404 with miss_way_valid=4'b0000; mem_ack with rdata=0x1234 two cycles after mem_req rises -> mem_addr=0x404; fill_valid one cycle with way=0, index=1, tag=1, data=0x1234; busy low the next cycle.
- Set 0 with miss_way_valid=4'b1111 and all PLRU bits 0 -> victim way0, after which the set's PLRU is {1,1,0}. A second miss to set 0 -> victim way2; a third -> way1; a fourth -> way3.
- Hit on set 5, way 2, then a full-valid miss to set 5 -> victim way0 (b0=0, b1=0).
- mem_ack held low for 20 cycles -> mem_req stays 1, miss_ready stays 0, and a second miss_valid is not accepted; on the ack, fill_valid occurs exactly one cycle later.
- rst asserted in REQ -> mem_req=0 at the next edge; a subsequent stray mem_ack produces no fill_valid; PLRU bits all 0.
- During FILL of set 3 way 1, hit_valid on set 3 way 3 in the same cycle -> final PLRU = {1,0,0}; fill_valid is not stretched beyond one cycle.

Source files
------------

// File: rtl/cache_refill_unit.sv
// Read-miss refill engine for a 4-way set-associative cache: victim choice,
// one outstanding memory read, single-cycle fill command, per-set tree PLRU.
module cache_refill_unit #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 22,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [31:0]        miss_addr,
  input  logic [3:0]         miss_way_valid,
  input  logic               hit_valid,
  input  logic [INDEX_W-1:0] hit_index,
  input  logic [1:0]         hit_way,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               fill_valid,
  output logic [1:0]         fill_way,
  output logic [INDEX_W-1:0] fill_index,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [DATA_W-1:0]  fill_data,
  output logic               busy
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t              state_reg, state_next;
  logic                miss_ready_reg, busy_reg, mem_req_reg, fill_valid_reg;
  logic [31:0]         mem_addr_reg, mem_addr_next;
  logic [1:0]          fill_way_reg, fill_way_next;
  logic [INDEX_W-1:0]  fill_index_reg, fill_index_next;
  logic [TAG_W-1:0]    fill_tag_reg, fill_tag_next;
  logic [DATA_W-1:0]   fill_data_reg, fill_data_next;

  logic [INDEX_W-1:0]  miss_index;
  logic [2:0]          miss_plru;
  logic [1:0]          victim_way;
  logic [2:0]          plru_bits [SETS];

  // Bit 0 is the root (0 = left pair older), bit 1 orders ways 0/1, bit 2 ways 2/3.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] r;
    r = bits;
    case (way)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
      localparam logic [INDEX_W-1:0] SET_ID = INDEX_W'(gi);
      logic [2:0] bits_reg, bits_next;

      // Hit is applied first so that the fill wins on any shared bit.
      always_comb begin
        bits_next = bits_reg;
        if (hit_valid && hit_index == SET_ID)
          bits_next = plru_touch(bits_next, hit_way);
        if (state_reg == FILL && fill_index_reg == SET_ID)
          bits_next = plru_touch(bits_next, fill_way_reg);
      end

      always_ff @(posedge clk) begin
        if (rst) bits_reg <= 3'b000;
        else     bits_reg <= bits_next;
      end

      assign plru_bits[gi] = bits_reg;
    end
  endgenerate

  assign miss_index = miss_addr[INDEX_W+1:2];
  assign miss_plru  = plru_bits[miss_index];

  always_comb begin
    victim_way = 2'd0;
    if      (!miss_way_valid[0]) victim_way = 2'd0;
    else if (!miss_way_valid[1]) victim_way = 2'd1;
    else if (!miss_way_valid[2]) victim_way = 2'd2;
    else if (!miss_way_valid[3]) victim_way = 2'd3;
    else if (!miss_plru[0])      victim_way = miss_plru[1] ? 2'd1 : 2'd0;
    else                         victim_way = miss_plru[2] ? 2'd3 : 2'd2;
  end

  always_comb begin
    state_next      = state_reg;
    mem_addr_next   = mem_addr_reg;
    fill_way_next   = fill_way_reg;
    fill_index_next = fill_index_reg;
    fill_tag_next   = fill_tag_reg;
    fill_data_next  = fill_data_reg;
    case (state_reg)
      IDLE: begin
        if (miss_valid) begin
          state_next      = REQ;
          mem_addr_next   = miss_addr & 32'hFFFF_FFFC;
          fill_way_next   = victim_way;
          fill_index_next = miss_index;
          fill_tag_next   = miss_addr[31:32-TAG_W];
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_next     = FILL;
          fill_data_next = mem_rdata;
        end
      end
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      miss_ready_reg <= 1'b1;
      busy_reg       <= 1'b0;
      mem_req_reg    <= 1'b0;
      fill_valid_reg <= 1'b0;
      mem_addr_reg   <= '0;
      fill_way_reg   <= '0;
      fill_index_reg <= '0;
      fill_tag_reg   <= '0;
      fill_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      miss_ready_reg <= (state_next == IDLE);
      busy_reg       <= (state_next != IDLE);
      mem_req_reg    <= (state_next == REQ);
      fill_valid_reg <= (state_next == FILL);
      mem_addr_reg   <= mem_addr_next;
      fill_way_reg   <= fill_way_next;
      fill_index_reg <= fill_index_next;
      fill_tag_reg   <= fill_tag_next;
      fill_data_reg  <= fill_data_next;
    end
  end

  assign miss_ready = miss_ready_reg;
  assign busy       = busy_reg;
  assign mem_req    = mem_req_reg;
  assign fill_valid = fill_valid_reg;
  assign mem_addr   = mem_addr_reg;
  assign fill_way   = fill_way_reg;
  assign fill_index = fill_index_reg;
  assign fill_tag   = fill_tag_reg;
  assign fill_data  = fill_data_reg;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Bench for cache_refill_unit: fixed vector table, corner-case sequences and
// randomized misses/hits checked against a tree-PLRU reference model.
module tb_cache_refill_unit;
  localparam int INDEX_W = 8;
  localparam int TAG_W   = 22;
  localparam int DATA_W  = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               miss_valid = 1'b0;
  logic               miss_ready;
  logic [31:0]        miss_addr = '0;
  logic [3:0]         miss_way_valid = '0;
  logic               hit_valid = 1'b0;
  logic [INDEX_W-1:0] hit_index = '0;
  logic [1:0]         hit_way = '0;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ack = 1'b0;
  logic [DATA_W-1:0]  mem_rdata = '0;
  logic               fill_valid;
  logic [1:0]         fill_way;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [DATA_W-1:0]  fill_data;
  logic               busy;

  always #5 clk = ~clk;

  cache_refill_unit #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_way_valid(miss_way_valid),
    .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_way(fill_way), .fill_index(fill_index),
    .fill_tag(fill_tag), .fill_data(fill_data), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] m_plru [256];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wv;
    int          delay;
    logic [31:0] rdata;
    logic [1:0]  exp_way;
    logic [7:0]  exp_index;
    logic [21:0] exp_tag;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a tree whose root says which pair is older, leaves say which way.
  function automatic logic [1:0] model_victim(input logic [7:0] idx, input logic [3:0] wv);
    for (int w = 0; w < 4; w++)
      if (!wv[w]) return 2'(w);
    if (m_plru[idx][0] == 1'b0) return m_plru[idx][1] ? 2'd1 : 2'd0;
    return m_plru[idx][2] ? 2'd3 : 2'd2;
  endfunction

  task automatic m_touch(input logic [7:0] idx, input logic [1:0] w);
    m_plru[idx][0] = (w < 2);
    if (w < 2) m_plru[idx][1] = (w == 0);
    else       m_plru[idx][2] = (w == 2);
  endtask

  task automatic m_clear();
    for (int s = 0; s < 256; s++) m_plru[s] = 3'b000;
  endtask

  task automatic idle_hit(input logic [7:0] idx, input logic [1:0] w);
    hit_valid = 1'b1; hit_index = idx; hit_way = w;
    m_touch(idx, w);
    step();
    hit_valid = 1'b0;
  endtask

  task automatic run_miss(input logic [31:0] addr, input logic [3:0] wv, input int delay,
                          input logic [31:0] rdata, input bit stray, input bit rnd_hits,
                          input bit fhit, input logic [7:0] fhit_idx, input logic [1:0] fhit_w,
                          output logic [1:0] way_o, output logic [7:0] idx_o,
                          output logic [21:0] tag_o);
    logic [7:0]  idx;
    logic [1:0]  exp_way;
    logic [31:0] exp_maddr;
    idx       = 8'((addr / 4) % 256);
    exp_maddr = addr - (addr % 4);
    exp_way   = model_victim(idx, wv);
    check("miss_ready_idle", 64'(miss_ready), 1);
    miss_valid = 1'b1; miss_addr = addr; miss_way_valid = wv;
    step();
    miss_valid = 1'b0; miss_way_valid = 4'($urandom);
    check("mem_req_rise", 64'(mem_req), 1);
    check("busy_req", 64'(busy), 1);
    check("miss_ready_req", 64'(miss_ready), 0);
    check("mem_addr", 64'(mem_addr), 64'(exp_maddr));
    for (int i = 0; i < delay; i++) begin
      if (stray) begin miss_valid = 1'b1; miss_addr = ~addr; miss_way_valid = 4'b0000; end
      if (rnd_hits && $urandom_range(0, 1) == 1) begin
        hit_valid = 1'b1;
        hit_index = 8'($urandom_range(0, 7));
        hit_way   = 2'($urandom);
        m_touch(hit_index, hit_way);
      end
      step();
      hit_valid = 1'b0;
      check("mem_req_hold", 64'(mem_req), 1);
      check("miss_ready_hold", 64'(miss_ready), 0);
      check("fill_valid_wait", 64'(fill_valid), 0);
      if (stray) check("mem_addr_hold", 64'(mem_addr), 64'(exp_maddr));
    end
    miss_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = rdata;
    step();
    // A stray ack during FILL must be ignored.
    mem_ack = 1'b1; mem_rdata = ~rdata;
    check("fill_valid", 64'(fill_valid), 1);
    check("fill_way", 64'(fill_way), 64'(exp_way));
    check("fill_index", 64'(fill_index), 64'(idx));
    check("fill_tag", 64'(fill_tag), 64'(addr / 1024));
    check("fill_data", 64'(fill_data), 64'(rdata));
    check("mem_req_drop", 64'(mem_req), 0);
    check("busy_fill", 64'(busy), 1);
    way_o = fill_way; idx_o = fill_index; tag_o = fill_tag;
    if (fhit) begin
      hit_valid = 1'b1; hit_index = fhit_idx; hit_way = fhit_w;
      m_touch(fhit_idx, fhit_w);
    end
    m_touch(idx, exp_way);
    step();
    hit_valid = 1'b0; mem_ack = 1'b0;
    check("fill_valid_drop", 64'(fill_valid), 0);
    check("busy_idle", 64'(busy), 0);
    check("miss_ready_back", 64'(miss_ready), 1);
    check("fill_data_stable", 64'(fill_data), 64'(rdata));
  endtask

  logic [1:0]  w_o;
  logic [7:0]  i_o;
  logic [21:0] t_o;
  logic [31:0] r_addr;
  logic [3:0]  r_wv;
  int          r_idle;

  initial begin
    vecs[0] = '{32'h0000_0404, 4'b0000, 2, 32'h0000_1234, 2'd0, 8'h01, 22'h1};
    vecs[1] = '{32'h0000_0000, 4'b1111, 0, 32'hAAAA_5555, 2'd0, 8'h00, 22'h0};
    vecs[2] = '{32'h0000_0003, 4'b1111, 1, 32'h0000_0001, 2'd2, 8'h00, 22'h0};
    vecs[3] = '{32'h0000_0C01, 4'b1111, 3, 32'hDEAD_BEEF, 2'd1, 8'h00, 22'h3};
    vecs[4] = '{32'hFFFF_FC00, 4'b1111, 0, 32'hFFFF_FFFF, 2'd3, 8'h00, 22'h3FFFFF};
    vecs[5] = '{32'h0000_001C, 4'b1011, 1, 32'h0000_0077, 2'd2, 8'h07, 22'h0};
    vecs[6] = '{32'h1234_5678, 4'b0110, 0, 32'h0000_005A, 2'd0, 8'h9E, 22'h48D15};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_clear();
    check("rst_miss_ready", 64'(miss_ready), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_mem_req", 64'(mem_req), 0);
    check("rst_fill_valid", 64'(fill_valid), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_fill_way", 64'(fill_way), 0);
    check("rst_fill_index", 64'(fill_index), 0);
    check("rst_fill_tag", 64'(fill_tag), 0);
    check("rst_fill_data", 64'(fill_data), 0);

    for (int v = 0; v < 7; v++) begin
      run_miss(vecs[v].addr, vecs[v].wv, vecs[v].delay, vecs[v].rdata, 1'b0, 1'b0,
               1'b0, 8'h0, 2'd0, w_o, i_o, t_o);
      check($sformatf("vec%0d_way", v), 64'(w_o), 64'(vecs[v].exp_way));
      check($sformatf("vec%0d_index", v), 64'(i_o), 64'(vecs[v].exp_index));
      check($sformatf("vec%0d_tag", v), 64'(t_o), 64'(vecs[v].exp_tag));
    end

    // Hit on set 5 way 2 steers the next full-valid victim to way 0.
    idle_hit(8'd5, 2'd2);
    run_miss(32'h0000_0014, 4'b1111, 1, 32'h0000_0505, 1'b0, 1'b0, 1'b0, 8'h0, 2'd0, w_o, i_o, t_o);
    check("hit_steer_way", 64'(w_o), 0);

    // Long memory latency with a competing miss held on the interface.
    run_miss(32'h0000_0824, 4'b1111, 20, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 8'h0, 2'd0, w_o, i_o, t_o);
    check("long_wait_index", 64'(i_o), 9);

    // Hit and fill on set 3 in the same cycle: final bits {1,0,0}.
    run_miss(32'h0000_000C, 4'b1101, 0, 32'h0000_0333, 1'b0, 1'b0, 1'b1, 8'd3, 2'd3, w_o, i_o, t_o);
    check("fillhit_way", 64'(w_o), 1);
    run_miss(32'h0000_040C, 4'b1111, 0, 32'h0000_0334, 1'b0, 1'b0, 1'b0, 8'h0, 2'd0, w_o, i_o, t_o);
    check("fillhit_next_way", 64'(w_o), 2);
    run_miss(32'h0000_080C, 4'b1111, 0, 32'h0000_0335, 1'b0, 1'b0, 1'b0, 8'h0, 2'd0, w_o, i_o, t_o);
    check("fillhit_third_way", 64'(w_o), 0);

    // Reset while waiting for memory aborts the miss and clears the PLRU state.
    miss_valid = 1'b1; miss_addr = 32'h0000_0014; miss_way_valid = 4'b1111;
    step();
    miss_valid = 1'b0;
    check("abort_mem_req_pre", 64'(mem_req), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_clear();
    check("abort_mem_req", 64'(mem_req), 0);
    check("abort_busy", 64'(busy), 0);
    check("abort_miss_ready", 64'(miss_ready), 1);
    check("abort_mem_addr", 64'(mem_addr), 0);
    check("abort_fill_tag", 64'(fill_tag), 0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_ack = 1'b0;
    check("stray_ack_fill", 64'(fill_valid), 0);
    check("stray_ack_busy", 64'(busy), 0);
    step();
    check("stray_ack_fill2", 64'(fill_valid), 0);
    run_miss(32'h0000_0014, 4'b1111, 0, 32'h0000_0606, 1'b0, 1'b0, 1'b0, 8'h0, 2'd0, w_o, i_o, t_o);
    check("post_reset_way", 64'(w_o), 0);

    // Randomized traffic on a few sets, hits interleaved in every state.
    for (int n = 0; n < 40; n++) begin
      r_idle = int'($urandom_range(0, 2));
      for (int j = 0; j < r_idle; j++)
        idle_hit(8'($urandom_range(0, 7)), 2'($urandom));
      r_addr = $urandom;
      r_addr[9:2] = 8'($urandom_range(0, 7));
      r_wv = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      run_miss(r_addr, r_wv, int'($urandom_range(0, 4)), $urandom, (n % 5) == 0, 1'b1,
               $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)), 2'($urandom),
               w_o, i_o, t_o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
